riv_async_fifo_side_ctl: RTL and testbench

//  One side (write or read) of an async FIFO, in that side's clock domain.
//  - Owns the local RAM address and a lap-extended pointer; any DEPTH, not only powers of 2.
//  - Publishes pointer snapshots to the far domain via a 4-phase req/ack handshake, sent only on change.
//  - Captures the far side's published pointer and derives level and full/empty.

---
 rtl/riv_async_fifo_pkg.sv | 50 +++++
 rtl/riv_async_fifo_ptr.sv | 29 ++
 rtl/riv_async_fifo_side_ctl.sv | 150 +++++++++++++++
 tb/tb_riv_async_fifo_side_ctl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riv_async_fifo_pkg.sv
// Shared types and pointer arithmetic for the async FIFO side controllers.
// Pointers are {lap, addr}. The addr field counts 0..DEPTH-1 for any DEPTH.
package riv_async_fifo_pkg;

    localparam int unsigned PTR_MAX_W = 17;

    typedef logic [PTR_MAX_W-1:0] ptr_max_t;

    typedef enum logic [1:0] {
        P_IDLE     = 2'd0,
        P_LOAD     = 2'd1,
        P_WAIT_LOW = 2'd2,
        P_REQ      = 2'd3
    } pub_fsm_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ACK  = 2'd1
    } rcv_fsm_t;

    // Next pointer. The last address wraps to 0 and flips the lap bit.
    function automatic ptr_max_t ptr_incr(input ptr_max_t p, input int unsigned depth);
        int unsigned aw      = $clog2(depth);
        ptr_max_t    lap_bit = ptr_max_t'(1) << aw;
        ptr_max_t    mask    = lap_bit - ptr_max_t'(1);
        ptr_max_t    res;
        if ((p & mask) == ptr_max_t'(depth - 1))
            res = (p & lap_bit) ^ lap_bit;
        else
            res = p + ptr_max_t'(1);
        return res;
    endfunction

    // Occupancy from a write pointer and a read pointer, 0..depth.
    function automatic ptr_max_t ptr_level(input ptr_max_t wr, input ptr_max_t rd,
                                           input int unsigned depth);
        int unsigned aw      = $clog2(depth);
        ptr_max_t    lap_bit = ptr_max_t'(1) << aw;
        ptr_max_t    mask    = lap_bit - ptr_max_t'(1);
        ptr_max_t    wa      = wr & mask;
        ptr_max_t    ra      = rd & mask;
        ptr_max_t    res;
        if ((wr & lap_bit) == (rd & lap_bit))
            res = wa - ra;
        else
            res = ptr_max_t'(depth) - ra + wa;
        return res;
    endfunction

endpackage

// File: rtl/riv_async_fifo_ptr.sv
// Lap-extended pointer counter {lap, addr}. The addr field wraps at DEPTH-1.
module riv_async_fifo_ptr
    import riv_async_fifo_pkg::*;
#(
    parameter  int unsigned DEPTH = 1024,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned PW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_ptr_next;

    assign w_ptr_next = PW'(ptr_incr(ptr_max_t'(r_ptr), DEPTH));

    always_ff @(posedge clk) begin
        if (rst)
            r_ptr <= '0;
        else if (inc)
            r_ptr <= w_ptr_next;
    end

    assign ptr = r_ptr;

endmodule

// File: rtl/riv_async_fifo_side_ctl.sv
// One side of an async FIFO. It owns the local pointer, publishes snapshots with a
// 4-phase handshake, captures the far pointer, and derives level and full/empty.
module riv_async_fifo_side_ctl
    import riv_async_fifo_pkg::*;
#(
    parameter  int unsigned DEPTH    = 1024,
    parameter  bit          IS_WRITE = 1'b1,
    localparam int unsigned AW       = $clog2(DEPTH),
    localparam int unsigned PW       = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [AW-1:0] addr,
    output logic [PW-1:0] ptr,
    output logic          flag,
    output logic [PW-1:0] level,
    output logic          err,
    output logic [PW-1:0] snap_ptr,
    output logic          snap_req,
    input  logic          snap_ack,
    input  logic [PW-1:0] rem_ptr,
    input  logic          rem_req,
    output logic          rem_ack
);

    logic [PW-1:0] w_ptr;
    logic [PW-1:0] w_wr;
    logic [PW-1:0] w_rd;
    logic [PW-1:0] w_level;
    logic          w_flag;
    logic          w_inc;

    logic [PW-1:0] r_snap_ptr;
    logic [PW-1:0] r_rem_ptr_q;
    logic          r_snap_req;
    logic          r_rem_ack;
    logic          r_err;
    pub_fsm_t      r_pub_state;
    rcv_fsm_t      r_rcv_state;

    assign w_inc = en & ~w_flag;

    riv_async_fifo_ptr #(
        .DEPTH (DEPTH)
    ) u_ptr (
        .clk (clk),
        .rst (rst),
        .inc (w_inc),
        .ptr (w_ptr)
    );

    // Level depends only on registers, so flag never has a path from en or rem_ptr.
    assign w_wr    = IS_WRITE ? w_ptr : r_rem_ptr_q;
    assign w_rd    = IS_WRITE ? r_rem_ptr_q : w_ptr;
    assign w_level = PW'(ptr_level(ptr_max_t'(w_wr), ptr_max_t'(w_rd), DEPTH));
    assign w_flag  = IS_WRITE ? (w_level == PW'(DEPTH)) : (w_level == '0);

    always_ff @(posedge clk) begin
        if (rst)
            r_err <= 1'b0;
        else
            r_err <= en & w_flag;
    end

    // Publish: snap_ptr is only reloaded after the previous ack was seen, so it is
    // stable for the whole time snap_req is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pub_state <= P_IDLE;
            r_snap_ptr  <= '0;
            r_snap_req  <= 1'b0;
        end else begin
            case (r_pub_state)
                P_IDLE: begin
                    r_snap_req <= 1'b0;
                    if (w_ptr != r_snap_ptr)
                        r_pub_state <= P_LOAD;
                end
                P_LOAD: begin
                    r_snap_ptr  <= w_ptr;
                    r_snap_req  <= 1'b0;
                    r_pub_state <= P_WAIT_LOW;
                end
                P_WAIT_LOW: begin
                    if (!snap_ack) begin
                        r_pub_state <= P_REQ;
                        r_snap_req  <= 1'b1;
                    end else begin
                        r_snap_req  <= 1'b0;
                    end
                end
                P_REQ: begin
                    if (snap_ack) begin
                        r_pub_state <= P_IDLE;
                        r_snap_req  <= 1'b0;
                    end else begin
                        r_snap_req  <= 1'b1;
                    end
                end
                default: begin
                    r_pub_state <= P_IDLE;
                    r_snap_req  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rcv_state <= R_IDLE;
            r_rem_ptr_q <= '0;
            r_rem_ack   <= 1'b0;
        end else begin
            case (r_rcv_state)
                R_IDLE: begin
                    if (rem_req) begin
                        r_rem_ptr_q <= rem_ptr;
                        r_rcv_state <= R_ACK;
                        r_rem_ack   <= 1'b1;
                    end else begin
                        r_rem_ack   <= 1'b0;
                    end
                end
                R_ACK: begin
                    if (!rem_req) begin
                        r_rcv_state <= R_IDLE;
                        r_rem_ack   <= 1'b0;
                    end else begin
                        r_rem_ack   <= 1'b1;
                    end
                end
                default: begin
                    r_rcv_state <= R_IDLE;
                    r_rem_ack   <= 1'b0;
                end
            endcase
        end
    end

    assign addr     = w_ptr[AW-1:0];
    assign ptr      = w_ptr;
    assign flag     = w_flag;
    assign level    = w_level;
    assign err      = r_err;
    assign snap_ptr = r_snap_ptr;
    assign snap_req = r_snap_req;
    assign rem_ack  = r_rem_ack;

endmodule

// File: tb/tb_riv_async_fifo_side_ctl.sv
// Directed bench: a write-side and a read-side instance with DEPTH=5,
// checked one step at a time against hand-computed values.
module tb_riv_async_fifo_side_ctl;

    logic       clk;
    logic       rst;

    logic       en_w, flag_w, err_w, snap_req_w, snap_ack_w, rem_req_w, rem_ack_w;
    logic [2:0] addr_w;
    logic [3:0] ptr_w, level_w, snap_ptr_w, rem_ptr_w;

    logic       en_r, flag_r, err_r, snap_req_r, snap_ack_r, rem_req_r, rem_ack_r;
    logic [2:0] addr_r;
    logic [3:0] ptr_r, level_r, snap_ptr_r, rem_ptr_r;

    int checks = 0;
    int errors = 0;

    riv_async_fifo_side_ctl #(.DEPTH(5), .IS_WRITE(1'b1)) dut_w (
        .clk      (clk),
        .rst      (rst),
        .en       (en_w),
        .addr     (addr_w),
        .ptr      (ptr_w),
        .flag     (flag_w),
        .level    (level_w),
        .err      (err_w),
        .snap_ptr (snap_ptr_w),
        .snap_req (snap_req_w),
        .snap_ack (snap_ack_w),
        .rem_ptr  (rem_ptr_w),
        .rem_req  (rem_req_w),
        .rem_ack  (rem_ack_w)
    );

    riv_async_fifo_side_ctl #(.DEPTH(5), .IS_WRITE(1'b0)) dut_r (
        .clk      (clk),
        .rst      (rst),
        .en       (en_r),
        .addr     (addr_r),
        .ptr      (ptr_r),
        .flag     (flag_r),
        .level    (level_r),
        .err      (err_r),
        .snap_ptr (snap_ptr_r),
        .snap_req (snap_req_r),
        .snap_ack (snap_ack_r),
        .rem_ptr  (rem_ptr_r),
        .rem_req  (rem_req_r),
        .rem_ack  (rem_ack_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        $display("check %s: observed=%0h expected=%0h", tag, obs, exp);
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        en_w = 1'b1; snap_ack_w = 1'b0; rem_ptr_w = '0; rem_req_w = 1'b0;
        en_r = 1'b1; snap_ack_r = 1'b0; rem_ptr_r = '0; rem_req_r = 1'b0;

        // 1. Reset with en held high
        repeat (3) step();
        check("rst_ptr_w",      ptr_w, 0);
        check("rst_addr_w",     addr_w, 0);
        check("rst_snap_ptr_w", snap_ptr_w, 0);
        check("rst_snap_req_w", snap_req_w, 0);
        check("rst_rem_ack_w",  rem_ack_w, 0);
        check("rst_err_w",      err_w, 0);
        check("rst_level_w",    level_w, 0);
        check("rst_flag_w",     flag_w, 0);
        check("rst_flag_r",     flag_r, 1);
        check("rst_level_r",    level_r, 0);
        check("rst_err_r",      err_r, 0);
        check("rst_ptr_r",      ptr_r, 0);
        check("rst_snap_req_r", snap_req_r, 0);
        check("rst_snap_ptr_r", snap_ptr_r, 0);
        rst = 1'b0; en_w = 1'b0; en_r = 1'b0;
        step();

        // 2. Wrap and full
        en_w = 1'b1;
        repeat (4) step();
        check("wr4_ptr",   ptr_w, 4);
        check("wr4_level", level_w, 4);
        check("wr4_flag",  flag_w, 0);
        step();
        check("wr5_ptr",   ptr_w, 4'b1000);
        check("wr5_addr",  addr_w, 0);
        check("wr5_level", level_w, 5);
        check("wr5_flag",  flag_w, 1);
        check("wr5_err",   err_w, 0);
        step();
        check("wr6_ptr",   ptr_w, 4'b1000);
        check("wr6_err",   err_w, 1);
        en_w = 1'b0;
        step();
        check("wr7_err",   err_w, 0);
        check("wr7_ptr",   ptr_w, 4'b1000);

        // 3. Publish
        rst = 1'b1;
        step();
        rst = 1'b0;
        en_w = 1'b1;
        step();
        en_w = 1'b0;
        check("pub_ptr",       ptr_w, 1);
        check("pub_snap_e1",   snap_ptr_w, 0);
        step();
        check("pub_snap_e2",   snap_ptr_w, 0);
        check("pub_req_e2",    snap_req_w, 0);
        step();
        check("pub_snap_e3",   snap_ptr_w, 1);
        check("pub_req_e3",    snap_req_w, 0);
        step();
        check("pub_req_e4",    snap_req_w, 1);
        for (int i = 0; i < 10; i++) begin
            step();
            check("pub_hold_req", snap_req_w, 1);
            check("pub_hold_ptr", snap_ptr_w, 1);
        end
        snap_ack_w = 1'b1;
        step();
        check("pub_ack_req",   snap_req_w, 0);
        step();
        snap_ack_w = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("pub_quiet_req", snap_req_w, 0);
        end

        // 4. Capture
        rst = 1'b1;
        step();
        rst = 1'b0;
        en_w = 1'b1;
        repeat (4) step();
        en_w = 1'b0;
        check("cap_ptr",       ptr_w, 4);
        check("cap_level_pre", level_w, 4);
        rem_ptr_w = 4'd2; rem_req_w = 1'b1;
        step();
        check("cap_ack_hi",    rem_ack_w, 1);
        check("cap_level",     level_w, 2);
        rem_req_w = 1'b0;
        step();
        check("cap_ack_lo",    rem_ack_w, 0);

        // 5. Cross-lap level
        en_w = 1'b1;
        repeat (2) step();
        en_w = 1'b0;
        check("xlap_ptr",      ptr_w, 4'b1001);
        check("xlap_addr",     addr_w, 1);
        check("xlap_level_pre", level_w, 4);
        rem_ptr_w = 4'd3; rem_req_w = 1'b1;
        step();
        check("xlap_level",    level_w, 3);
        check("xlap_flag",     flag_w, 0);
        check("xlap_ack",      rem_ack_w, 1);
        rem_req_w = 1'b0;
        step();
        check("xlap_ack_lo",   rem_ack_w, 0);

        // 6. Reset mid-handshake
        rst = 1'b1;
        step();
        rst = 1'b0;
        en_w = 1'b1;
        step();
        en_w = 1'b0;
        repeat (3) step();
        check("mid_req_hi",    snap_req_w, 1);
        rst = 1'b1;
        step();
        check("mid_req_rst",   snap_req_w, 0);
        check("mid_snap_rst",  snap_ptr_w, 0);
        check("mid_ptr_rst",   ptr_w, 0);
        rst = 1'b0;
        en_w = 1'b1;
        step();
        en_w = 1'b0;
        repeat (2) step();
        check("mid_repub_ptr", snap_ptr_w, 1);
        step();
        check("mid_repub_req", snap_req_w, 1);
        snap_ack_w = 1'b1;
        step();
        check("mid_ack_req",   snap_req_w, 0);
        snap_ack_w = 1'b0;

        // Read side: empty guard, fill via capture, drain across the lap
        en_r = 1'b1;
        step();
        check("rd_empty_err",  err_r, 1);
        check("rd_empty_ptr",  ptr_r, 0);
        en_r = 1'b0;
        step();
        check("rd_err_lo",     err_r, 0);
        rem_ptr_r = 4'b1000; rem_req_r = 1'b1;
        step();
        check("rd_cap_ack",    rem_ack_r, 1);
        check("rd_cap_level",  level_r, 5);
        check("rd_cap_flag",   flag_r, 0);
        rem_req_r = 1'b0;
        step();
        check("rd_cap_ack_lo", rem_ack_r, 0);
        en_r = 1'b1;
        repeat (5) step();
        en_r = 1'b0;
        check("rd5_ptr",       ptr_r, 4'b1000);
        check("rd5_addr",      addr_r, 0);
        check("rd5_level",     level_r, 0);
        check("rd5_flag",      flag_r, 1);
        step();
        check("rd5_err",       err_r, 0);
        rem_ptr_r = 4'b1001; rem_req_r = 1'b1;
        step();
        check("rd_cap2_level", level_r, 1);
        check("rd_cap2_flag",  flag_r, 0);
        rem_req_r = 1'b0;
        en_r = 1'b1;
        step();
        en_r = 1'b0;
        check("rd6_ptr",       ptr_r, 4'b1001);
        check("rd6_level",     level_r, 0);
        check("rd6_flag",      flag_r, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
